// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction controller: FSM states,
// opcode/op encodings, write-back selects and IR field widths.
package cpu_pkg;

  localparam int WORD_W = 16;
  localparam int REG_W  = 3;
  localparam int OPC_W  = 3;
  localparam int OP_W   = 2;
  localparam int SH_W   = 2;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_ALU    = 3'd4,
    S_WB     = 3'd5,
    S_WR_IMM = 3'd6
  } state_e;

  localparam logic [OPC_W-1:0] OP_MOV = 3'b110;
  localparam logic [OPC_W-1:0] OP_ALU = 3'b101;

  localparam logic [OP_W-1:0] MOV_REG = 2'b00;
  localparam logic [OP_W-1:0] MOV_IMM = 2'b10;

  localparam logic [OP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [OP_W-1:0] ALU_CMP = 2'b01;
  localparam logic [OP_W-1:0] ALU_AND = 2'b10;
  localparam logic [OP_W-1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;

  function automatic logic is_legal(input logic [OPC_W-1:0] opc, input logic [OP_W-1:0] op);
    is_legal = ((opc == OP_MOV) && ((op == MOV_IMM) || (op == MOV_REG))) || (opc == OP_ALU);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational field extraction from the instruction register, including
// the two sign-extended immediates and the supported-instruction flag.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0] ir_i,
  output logic [OPC_W-1:0]  opcode_o,
  output logic [OP_W-1:0]   op_o,
  output logic [REG_W-1:0]  rn_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [REG_W-1:0]  rm_o,
  output logic [SH_W-1:0]   sh_o,
  output logic [WORD_W-1:0] sximm5_o,
  output logic [WORD_W-1:0] sximm8_o,
  output logic              legal_o
);

  assign opcode_o = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};
  assign legal_o  = is_legal(opcode_o, op_o);

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore FSM that sequences the register file,
// A/B/C/status loads and ALU controls for one instruction per start pulse.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RBITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             s,
  output logic             w,
  output logic             illegal,
  output logic [RBITS-1:0] readnum,
  output logic [RBITS-1:0] writenum,
  output logic             write,
  output logic [1:0]       vsel,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] sximm8,
  output logic [WIDTH-1:0] sximm5
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ir_q, ir_d;
  logic [OPC_W-1:0]   opcode;
  logic [OP_W-1:0]    op;
  logic [REG_W-1:0]   rn, rd, rm;
  logic [SH_W-1:0]    sh;
  logic               legal;
  logic               is_mov;

  instr_decoder u_dec (
    .ir_i     (ir_q),
    .opcode_o (opcode),
    .op_o     (op),
    .rn_o     (rn),
    .rd_o     (rd),
    .rm_o     (rm),
    .sh_o     (sh),
    .sximm5_o (sximm5),
    .sximm8_o (sximm8),
    .legal_o  (legal)
  );

  assign is_mov  = (opcode == OP_MOV);
  assign w       = (state_q == S_WAIT);
  assign illegal = (state_q == S_DECODE) && !legal;

  // State and instruction register update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and Moore output decode; IR only accepts a word while idle
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    readnum  = {RBITS{1'b0}};
    writenum = {RBITS{1'b0}};
    write    = 1'b0;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state_q)
      S_WAIT: begin
        if (load) begin
          ir_d = in;
        end else begin
          ir_d = ir_q;
        end
        if (s) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_WAIT;
        end else if (is_mov && (op == MOV_IMM)) begin
          state_d = S_WR_IMM;
        end else if (is_mov || (op == ALU_MVN)) begin
          state_d = S_GET_B;
        end else begin
          state_d = S_GET_A;
        end
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        // MOV reg is computed as 0 + shifted B by zeroing the A side
        shift = sh;
        asel  = is_mov;
        if (is_mov) begin
          ALUop = ALU_ADD;
        end else begin
          ALUop = op;
        end
        if (!is_mov && (op == ALU_CMP)) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_WR_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench: controller drives a behavioural datapath; results are
// compared against an instruction-level reference model and fixed vectors.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset, load, s;
  logic [15:0] instr_in;
  logic        w, illegal, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .reset(reset), .in(instr_in), .load(load), .s(s),
    .w(w), .illegal(illegal), .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .shift(shift), .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5)
  );

  // behavioural datapath driven by the controller
  logic [15:0] r_m [8];
  logic [15:0] a_m, b_m, c_m;
  logic [2:0]  f_m;
  // instruction-level reference state
  logic [15:0] r_x [8];
  logic [2:0]  f_x;

  int checks = 0;
  int failures = 0;
  int ill_cnt, wr_cnt;

  typedef struct {
    logic [15:0] ir;
    int          sel;   // 0..7 register to spot-check, 8 = flags
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] shf(input logic [15:0] x, input logic [1:0] k);
    case (k)
      2'b01:   return x << 1;
      2'b10:   return x >> 1;
      2'b11:   return {x[15], x[15:1]};
      default: return x;
    endcase
  endfunction

  task automatic dp_step();
    logic [15:0] rd_val, ain, bin, alu;
    logic        v;
    rd_val = r_m[readnum];
    ain = asel ? 16'h0000 : a_m;
    bin = bsel ? sximm5 : shf(b_m, shift);
    case (ALUop)
      2'b00:   alu = ain + bin;
      2'b01:   alu = ain - bin;
      2'b10:   alu = ain & bin;
      default: alu = ~bin;
    endcase
    if (ALUop == 2'b01) v = (ain[15] != bin[15]) && (alu[15] != ain[15]);
    else                v = (ain[15] == bin[15]) && (alu[15] != ain[15]);
    if (illegal) ill_cnt++;
    if (write) begin
      wr_cnt++;
      r_m[writenum] = (vsel == 2'b10) ? sximm8 : c_m;
    end
    if (loada) a_m = rd_val;
    if (loadb) b_m = rd_val;
    if (loadc) c_m = alu;
    if (loads) f_m = {alu[15], v, (alu == 16'h0000)};
  endtask

  task automatic cyc();
    @(negedge clk);
    dp_step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_lat(input logic [15:0] ir);
    if (ir[15:13] == 3'b110 && ir[12:11] == 2'b10) return 3;
    if (ir[15:13] == 3'b110 && ir[12:11] == 2'b00) return 5;
    if (ir[15:13] == 3'b101) return (ir[12:11] == 2'b00 || ir[12:11] == 2'b10) ? 6 : 5;
    return 2;
  endfunction

  task automatic ref_exec(input logic [15:0] ir);
    logic [15:0] a, b, d;
    a = r_x[ir[10:8]];
    b = shf(r_x[ir[2:0]], ir[4:3]);
    if (ir[15:13] == 3'b110 && ir[12:11] == 2'b10) r_x[ir[10:8]] = {{8{ir[7]}}, ir[7:0]};
    else if (ir[15:13] == 3'b110 && ir[12:11] == 2'b00) r_x[ir[7:5]] = b;
    else if (ir[15:13] == 3'b101) begin
      case (ir[12:11])
        2'b00: r_x[ir[7:5]] = a + b;
        2'b01: begin
          d = a - b;
          f_x = {d[15], (a[15] != b[15]) && (d[15] != a[15]), (d == 16'h0000)};
        end
        2'b10:   r_x[ir[7:5]] = a & b;
        default: r_x[ir[7:5]] = ~b;
      endcase
    end
  endtask

  task automatic run_instr(input logic [15:0] ir, input bit disturb, output int edges);
    ill_cnt = 0;
    wr_cnt = 0;
    instr_in = ir;
    load = 1'b1;
    s = 1'b1;
    cyc();
    load = 1'b0;
    s = 1'b0;
    edges = 1;
    while (!w && edges < 20) begin
      if (disturb && edges < 4) begin
        load = 1'b1; s = 1'b1; instr_in = ~ir;
      end else begin
        load = 1'b0; s = 1'b0;
      end
      cyc();
      edges++;
    end
    load = 1'b0;
    s = 1'b0;
  endtask

  task automatic check_regs(input string nm);
    for (int i = 0; i < 8; i++) chk($sformatf("%s R%0d", nm, i), {16'h0, r_m[i]}, {16'h0, r_x[i]});
    chk($sformatf("%s flags", nm), {29'h0, f_m}, {29'h0, f_x});
  endtask

  task automatic check_instr(input string nm, input logic [15:0] ir, input bit disturb);
    int e, lat;
    bit no_wr;
    lat = ref_lat(ir);
    no_wr = (lat == 2) || (ir[15:11] == 5'b10101);
    ref_exec(ir);
    run_instr(ir, disturb, e);
    chk($sformatf("%s latency", nm), e, lat);
    chk($sformatf("%s illegal pulses", nm), ill_cnt, (lat == 2) ? 1 : 0);
    chk($sformatf("%s writes", nm), wr_cnt, no_wr ? 0 : 1);
    chk($sformatf("%s sximm8", nm), {16'h0, sximm8}, {16'h0, {8{ir[7]}}, ir[7:0]});
    chk($sformatf("%s sximm5", nm), {16'h0, sximm5}, {16'h0, {11{ir[4]}}, ir[4:0]});
    check_regs(nm);
  endtask

  task automatic check_idle(input string nm);
    chk($sformatf("%s ctrl", nm),
        {11'h0, w, illegal, write, loada, loadb, loadc, loads, asel, bsel,
         readnum, writenum, shift, ALUop, vsel},
        {11'h0, 1'b1, 20'h0});
    chk($sformatf("%s imm", nm), {sximm8, sximm5}, 32'h0);
  endtask

  task automatic preset(input int idx, input logic [15:0] v);
    r_m[idx] = v;
    r_x[idx] = v;
  endtask

  vec_t vecs [9];
  logic [4:0] leg [6];

  initial begin
    vecs[0] = '{16'hD025, 0, 16'h0025};
    vecs[1] = '{16'hA543, 2, 16'h0065};
    vecs[2] = '{16'hAB00, 8, 16'h0000};
    vecs[3] = '{16'hAE04, 8, 16'h0004};
    vecs[4] = '{16'hB861, 3, 16'hFFB8};
    vecs[5] = '{16'hC089, 4, 16'h008E};
    vecs[6] = '{16'hB5E1, 7, 16'h0003};
    vecs[7] = '{16'hE000, 0, 16'h0025};
    vecs[8] = '{16'hC800, 0, 16'h0025};
    leg = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

    reset = 1'b1; load = 1'b0; s = 1'b0; instr_in = 16'h0000;
    for (int i = 0; i < 8; i++) preset(i, 16'h0000);
    a_m = 16'h0; b_m = 16'h0; c_m = 16'h0; f_m = 3'b000; f_x = 3'b000;
    cyc();
    cyc();
    reset = 1'b0;
    check_idle("reset");

    preset(3, 16'h0042); preset(5, 16'h0023); preset(1, 16'h0047);
    preset(6, 16'h0000); preset(4, 16'h0044);
    for (int i = 0; i < 9; i++) begin
      check_instr($sformatf("vec%0d", i), vecs[i].ir, 1'b0);
      if (vecs[i].sel < 8) chk($sformatf("vec%0d value", i), {16'h0, r_m[vecs[i].sel]}, {16'h0, vecs[i].exp});
      else                 chk($sformatf("vec%0d nvz", i), {29'h0, f_m}, {29'h0, vecs[i].exp[2:0]});
    end

    // reset while an ADD sits in GET_B abandons it without a write
    preset(3, 16'h0042); preset(5, 16'h0023); preset(2, 16'h1234);
    wr_cnt = 0; ill_cnt = 0;
    instr_in = 16'hA543; load = 1'b1; s = 1'b1;
    cyc();
    load = 1'b0; s = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_idle("mid reset");
    chk("mid reset writes", wr_cnt, 0);
    check_regs("mid reset");

    // load/s while busy must not disturb the running ADD
    check_instr("busy ignore", 16'hA543, 1'b1);
    chk("busy ignore R2", {16'h0, r_m[2]}, 32'h0000_0065);

    for (int n = 0; n < 60; n++) begin
      logic [15:0] ir;
      ir = 16'($urandom);
      if ($urandom_range(7) != 0) ir[15:11] = leg[$urandom_range(5)];
      if ($urandom_range(3) == 0) preset($urandom_range(7), 16'($urandom));
      check_instr($sformatf("rand%0d %h", n, ir), ir, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
